// File: rtl/lzd_pkg.sv
// Shared constants and tag type for the shared leading-zero-detector scheduler.
package lzd_pkg;
  localparam int LZD_W   = 32;
  localparam int LZD_PW  = 5;
  localparam int LZD_LAT = 5;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } tag_t;
endpackage

// File: rtl/lzd_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: rotate requests by ptr, pick the first, un-rotate into a one-hot grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PTRW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PTRW-1:0] gnt_id,
  output logic [PTRW-1:0] next_ptr
);
  logic [NREQ-1:0] rot;
  logic            found;
  int              idx;

  always_comb begin
    rot      = '0;
    gnt      = '0;
    gnt_id   = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    // rot[k] is requester (ptr + k) mod NREQ, so rot[0] has highest priority
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      rot[k] = req[idx];
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && rot[k]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = PTRW'(idx);
        next_ptr = (idx == NREQ - 1) ? '0 : PTRW'(idx + 1);
      end
    end
  end
endmodule

// File: rtl/lzd_share_ctrl.sv
// Shares one pipelined LZD among NREQ requesters; tags ride a delay line matched to the LZD.
// Optional per-requester grant counters are built when LZD_SHARE_STATS_EN is defined.
module lzd_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int W       = lzd_pkg::LZD_W,
  parameter int PW      = lzd_pkg::LZD_PW,
  parameter int LZD_LAT = lzd_pkg::LZD_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*W-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [W-1:0]              lzd_a,
  input  logic [PW-1:0]             lzd_p,
  input  logic                      lzd_v,
`ifdef LZD_SHARE_STATS_EN
  input  logic [$clog2(NREQ)-1:0]   stat_sel,
  input  logic                      stat_clr,
  output logic [15:0]               stat_cnt,
`endif
  output logic [NREQ-1:0]           rsp_valid,
  output logic [PW-1:0]             rsp_pos,
  output logic                      rsp_zero
);
  import lzd_pkg::*;

  localparam int PTRW = $clog2(NREQ);

  // Valid/ready: a transfer happens on a rising edge where req_valid[i] & req_ready[i];
  // req_ready is one-hot, combinational, and never asserted without the matching valid.
  logic [PTRW-1:0] ptr;
  logic [PTRW-1:0] next_ptr;
  logic [PTRW-1:0] gnt_id;
  logic            fire;
  tag_t            tags [0:LZD_LAT];
  tag_t            last;

  rr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .gnt      (req_ready),
    .gnt_id   (gnt_id),
    .next_ptr (next_ptr)
  );

  assign fire = |req_ready;
  // Stage 0 loads with lzd_a; the last stage lines up with lzd_p being valid.
  assign last = tags[LZD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      lzd_a <= '0;
      for (int k = 0; k <= LZD_LAT; k++) tags[k] <= '0;
    end else begin
      if (fire) begin
        ptr   <= next_ptr;
        lzd_a <= req_data[int'(gnt_id)*W +: W];
      end
      tags[0] <= fire ? tag_t'{valid: 1'b1, id: 3'(gnt_id)} : '0;
      for (int k = 1; k <= LZD_LAT; k++) tags[k] <= tags[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_pos   <= '0;
      rsp_zero  <= 1'b0;
    end else if (last.valid) begin
      rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << last.id;
      rsp_pos   <= lzd_v ? lzd_p : '0;
      rsp_zero  <= ~lzd_v;
    end else begin
      rsp_valid <= '0;
    end
  end

`ifdef LZD_SHARE_STATS_EN
  logic [15:0] cnt [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) cnt[k] <= '0;
      stat_cnt <= '0;
    end else begin
      if (stat_clr) begin
        for (int k = 0; k < NREQ; k++) cnt[k] <= '0;
      end else if (fire && cnt[gnt_id] != 16'hFFFF) begin
        cnt[gnt_id] <= cnt[gnt_id] + 16'd1;
      end
      stat_cnt <= (int'(stat_sel) < NREQ) ? cnt[stat_sel] : '0;
    end
  end
`endif
endmodule

// File: tb/tb_lzd_share_ctrl.sv
// Directed bench for lzd_share_ctrl with a behavioural 5-stage LZD model; define
// LZD_SHARE_STATS_EN to also exercise the grant counters.
module tb_lzd_share_ctrl;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int PW   = 5;
  localparam int LAT  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      lzd_a;
  logic [PW-1:0]     lzd_p;
  logic              lzd_v;
  logic [NREQ-1:0]   rsp_valid;
  logic [PW-1:0]     rsp_pos;
  logic              rsp_zero;
`ifdef LZD_SHARE_STATS_EN
  logic [1:0]        stat_sel = '0;
  logic              stat_clr = 1'b0;
  logic [15:0]       stat_cnt;
`endif

  lzd_share_ctrl #(.NREQ(NREQ), .W(W), .PW(PW), .LZD_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .lzd_a     (lzd_a),
    .lzd_p     (lzd_p),
    .lzd_v     (lzd_v),
`ifdef LZD_SHARE_STATS_EN
    .stat_sel  (stat_sel),
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt),
`endif
    .rsp_valid (rsp_valid),
    .rsp_pos   (rsp_pos),
    .rsp_zero  (rsp_zero)
  );

  always #5 clk = ~clk;

  // LZD model: leading-zero count, garbage position for zero input, LAT edges of latency
  logic [PW:0] lzd_pipe [LAT];
  function automatic logic [PW:0] lzd_f(input logic [W-1:0] a);
    logic [PW:0] r;
    r = {1'b0, 5'h1f};
    for (int b = 0; b < W; b++) if (a[b]) r = {1'b1, 5'(W - 1 - b)};
    return r;
  endfunction
  always @(posedge clk) begin
    lzd_pipe[0] <= lzd_f(lzd_a);
    for (int k = 1; k < LAT; k++) lzd_pipe[k] <= lzd_pipe[k-1];
  end
  assign lzd_v = lzd_pipe[LAT-1][PW];
  assign lzd_p = lzd_pipe[LAT-1][PW-1:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entries: {cycle, rsp_valid, rsp_pos, rsp_zero}
  logic [41:0] exp_q[$];
  logic [41:0] got_q[$];
  always @(negedge clk) if (rsp_valid != '0) got_q.push_back({32'(cyc), rsp_valid, rsp_pos, rsp_zero});

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just before the accepting edge; the strobe is seen 6 edges after it.
  task automatic expect_rsp(input int id, input logic [4:0] pos, input logic zero);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    exp_q.push_back({32'(cyc + 1 + LAT + 1), oh, pos, zero});
  endtask

  task automatic drain(input string tag, input int n);
    repeat (n) step();
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) check(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input int id, input logic [31:0] data, input logic [4:0] pos, input logic zero);
    req_valid = 4'b0001 << id;
    req_data[id*W +: W] = data;
    #1;
    check("send_ready", 64'(req_ready), 64'(4'b0001 << id));
    expect_rsp(id, pos, zero);
    step();
    req_valid = '0;
    check("send_lzd_a", 64'(lzd_a), 64'(data));
  endtask

  logic [31:0] data8 [8];
  logic [4:0]  pos8  [8];

  initial begin
    data8 = '{32'h4000_0000, 32'h0000_8000, 32'h0000_0003, 32'h0100_0000,
              32'h0020_0000, 32'h0000_0001, 32'h1234_5678, 32'h00FF_0000};
    pos8  = '{5'd1, 5'd16, 5'd30, 5'd7, 5'd10, 5'd31, 5'd3, 5'd8};

    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_pos", 64'(rsp_pos), 64'h0);
    check("rst_rsp_zero", 64'(rsp_zero), 64'h0);
    check("rst_lzd_a", 64'(lzd_a), 64'h0);
    check("idle_ready", 64'(req_ready), 64'h0);

    // Single transfer, latency and position
    send(2, 32'h0001_0000, 5'd15, 1'b0);
    drain("single", 10);
    check("pos_holds", 64'(rsp_pos), 64'd15);

    // Zero and MSB-set operands
    send(1, 32'h0000_0000, 5'd0, 1'b1);
    send(3, 32'h8000_0000, 5'd0, 1'b0);
    drain("edge_ops", 10);

    // All requesters valid: rotation 0,1,2,3,0,... with no bubbles
    req_valid = 4'hF;
    for (int s = 0; s < 8; s++) begin
      req_data[(s % 4)*W +: W] = data8[s];
      #1;
      check("rotate_ready", 64'(req_ready), 64'(4'b0001 << (s % 4)));
      expect_rsp(s % 4, pos8[s], 1'b0);
      step();
    end
    req_valid = '0;
    drain("rotate", 10);

    // Requester 3 alone for 4 grants, then requester 0 wins after ptr wraps
    req_valid = 4'b1000;
    req_data[3*W +: W] = 32'h0000_0100;
    for (int s = 0; s < 4; s++) begin
      #1;
      check("solo_ready", 64'(req_ready), 64'h8);
      expect_rsp(3, 5'd23, 1'b0);
      step();
    end
    req_valid = 4'b1001;
    req_data[0*W +: W] = 32'h0000_0010;
    #1;
    check("wrap_ready", 64'(req_ready), 64'h1);
    expect_rsp(0, 5'd27, 1'b0);
    step();
    req_valid = '0;
    drain("solo", 10);

    // Reset with three transfers in flight
    req_valid = 4'b0111;
    req_data[0*W +: W] = 32'h0000_0F00;
    req_data[1*W +: W] = 32'h00F0_0000;
    req_data[2*W +: W] = 32'h0000_0002;
    repeat (3) step();
    req_valid = '0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_lzd_a", 64'(lzd_a), 64'h0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    drain("after_rst", 12);
    check("after_rst_pos", 64'(rsp_pos), 64'h0);
    check("after_rst_zero", 64'(rsp_zero), 64'h0);
    req_valid = 4'hF;
    req_data[0*W +: W] = 32'h0000_0400;
    #1;
    check("after_rst_ready", 64'(req_ready), 64'h1);
    expect_rsp(0, 5'd21, 1'b0);
    step();
    req_valid = 4'b1010;
    #1;
    check("after_rst_next", 64'(req_ready), 64'h2);
    req_valid = '0;
    drain("after_rst_op", 10);

`ifdef LZD_SHARE_STATS_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    stat_sel = 2'd0;
    req_valid = 4'b0001;
    repeat (70000) step();
    req_valid = '0;
    step();
    step();
    check("stat_sat", 64'(stat_cnt), 64'hFFFF);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    step();
    check("stat_clr", 64'(stat_cnt), 64'h0);
    repeat (10) step();
    got_q.delete();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
